spart_receiver: RTL
===================

Name: spart_receiver

Overview:
- Receive half of the SPART; mirrors the existing transmitter.
- Deserialises the asynchronous 8N1 stream on rxd using the 16x oversample enable from the baud downcounter.
- Holds the received byte for the processor and reports status flags (rda, framing error, overrun).
- Instantiated in spart beside the transmitter; the top level drives rx_data onto databus on a status/data read.

Parameters:
- OVERSAMPLE, 16, baud_en ticks per bit; must be even and at least 4.
- DATA_BITS, 8, payload bits per frame, sent LSB first.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- baud_en  input  1  single-cycle oversample tick (OVERSAMPLE per bit time).
- rxd  input  1  serial input; asynchronous; idles high.
- rd_en  input  1  single-cycle read strobe (iocs & ioaddr==2'b00 & iorw==1).
- rx_data  output  DATA_BITS  last good received byte.
- rda  output  1  receive data available.
- frame_err  output  1  sticky; stop bit sampled low.
- overrun  output  1  sticky; byte completed while rda was already 1.

Behaviour:
- Reset (rst=0, asynchronous): rx_data=0, rda=0, frame_err=0, overrun=0, state=IDLE, tick counter=0, bit counter=0, synchroniser flops=1.
- rxd passes through a 2-flop synchroniser (reset to 1) before any use. Added latency is 2 clk.
- FSM advances only on cycles with baud_en=1, except the rd_en clear logic, which acts on every clk.
- IDLE: on a tick with synced rxd=0 -> START, tick_cnt=0.
- START: tick_cnt increments on each tick. At tick_cnt==OVERSAMPLE/2-1 (mid start bit):
  - rxd=1: false start -> IDLE, no flags changed.
  - rxd=0: tick_cnt=0, bit_cnt=0 -> DATA.
- DATA: at tick_cnt==OVERSAMPLE-1 (mid bit), shift rxd into shift_reg MSB (right shift, so first bit lands in LSB), tick_cnt=0, bit_cnt+1.
  - When bit_cnt reaches DATA_BITS-1 and that bit is sampled -> STOP.
- STOP: at tick_cnt==OVERSAMPLE-1, sample rxd:
  - 1: rx_data<=shift_reg; rda<=1; overrun<=1 if rda was already 1 and no rd_en this cycle. -> IDLE.
  - 0: rx_data and rda unchanged; frame_err<=1. -> BRK_WAIT.
- BRK_WAIT: stay until a tick with rxd=1, then -> IDLE. This stops a break/low line from being re-taken as a start bit.
- rda, frame_err and overrun are registered. They assert on the clk edge of the stop-sampling tick and are visible the next cycle.
- rd_en clears rda, frame_err and overrun on the next edge.
- rd_en in the same cycle as a good-stop load: load wins. rda stays 1, rx_data gets the new byte, overrun stays unchanged (0 if it was clear), frame_err cleared.
- rd_en in the same cycle as a framing error: frame_err stays 1, rda cleared.
- rx_data is never cleared by a read. It holds until the next good frame.
- Overrun policy: the new byte overwrites the old one.
- Counters use clog2(OVERSAMPLE) and clog2(DATA_BITS+1) bits. No wrap is possible, because each counter resets at its terminal value.
- rst asserted mid-frame: everything returns to reset values immediately. After rst releases, the receiver waits in IDLE. A line already low is taken as a start bit, and that partial frame resolves as a good frame or as a framing error per the rules above.

Decomposition:
- Shared package spart_pkg holds:
  - FSM state encodings IDLE, START, DATA, STOP, BRK_WAIT (3-bit).
  - Default OVERSAMPLE=16 and DATA_BITS=8.
  - The read-address constant 2'b00. The transmitter uses the same constants.
- One natural sub-module: spart_sync2, a 2-flop synchroniser with an asynchronous active-low reset value of 1. It is reusable for other asynchronous inputs.

Test Plan:
- Good frame: baud_en every clk, send 0xA5 as 8N1 at 16 clk/bit -> rda=1 and rx_data=0xA5 about 2 clk after stop-bit mid; frame_err=0, overrun=0.
- Glitch: rxd low for 5 ticks, then high -> rda stays 0, FSM back in IDLE, next frame 0x3C received correctly.
- Framing error: send 0x3C with stop bit 0, held low for 3 bit times -> frame_err=1, rda=0, rx_data unchanged. No new start until rxd goes high. Next frame 0x55 received, frame_err stays 1 until rd_en.
- Overrun: send 0x11 then 0x22 with no rd_en -> rx_data=0x22, rda=1, overrun=1. A single rd_en pulse -> rda=0, overrun=0, rx_data=0x22.
- Read collision: rd_en pulsed on the exact cycle 0x77 completes while rda=1 holds 0x66 -> rx_data=0x77, rda=1, overrun=0.
- Reset mid-frame: assert rst during data bit 3 of 0xF0 -> all outputs 0 asynchronously. Release with line idle, send 0x81 -> rx_data=0x81, rda=1.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared SPART constants and FSM encodings; the transmitter imports the same package.
package spart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    BRK_WAIT = 3'd4
  } spart_state_e;

  localparam int         SPART_OVERSAMPLE = 16;
  localparam int         SPART_DATA_BITS  = 8;
  localparam logic [1:0] SPART_ADDR_DATA  = 2'b00;

endpackage

// File: rtl/spart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high input; resets to 1.
module spart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b1;
      o_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/spart_receiver.sv
// SPART receive half: 8N1 deserialiser on the baud oversample tick, with
// held byte and sticky status flags for the processor.
module spart_receiver
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = SPART_OVERSAMPLE,
  parameter int DATA_BITS  = SPART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_en,
  input  logic                 rxd,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 w_rxd;
  logic                 w_stop_tick;
  logic                 w_good;
  logic                 w_ferr;
  spart_state_e         r_state;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;

  spart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rxd),
    .o_q (w_rxd)
  );

  assign w_stop_tick = baud_en && (r_state == STOP) && (r_tick_cnt == TICK_FULL);
  assign w_good      = w_stop_tick &&  w_rxd;
  assign w_ferr      = w_stop_tick && !w_rxd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      rx_data    <= '0;
      rda        <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (baud_en) begin
        case (r_state)
          IDLE: if (!w_rxd) begin
            r_state    <= START;
            r_tick_cnt <= '0;
          end
          START: if (r_tick_cnt == TICK_HALF) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_state    <= w_rxd ? IDLE : DATA;
          end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
          // LSB arrives first, so shift right from the top.
          DATA: if (r_tick_cnt == TICK_FULL) begin
            r_tick_cnt <= '0;
            r_shift    <= {w_rxd, r_shift[DATA_BITS-1:1]};
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BIT_LAST) r_state <= STOP;
          end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
          STOP: if (r_tick_cnt == TICK_FULL) begin
            r_tick_cnt <= '0;
            r_state    <= w_rxd ? IDLE : BRK_WAIT;
          end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
          BRK_WAIT: if (w_rxd) r_state <= IDLE;
          default:  r_state <= IDLE;
        endcase
      end

      // A completing frame takes priority over a coincident read.
      if (w_good) begin
        rx_data <= r_shift;
        rda     <= 1'b1;
        if (rd_en)    frame_err <= 1'b0;
        else if (rda) overrun   <= 1'b1;
      end else if (w_ferr) begin
        frame_err <= 1'b1;
        if (rd_en) begin
          rda     <= 1'b0;
          overrun <= 1'b0;
        end
      end else if (rd_en) begin
        rda       <= 1'b0;
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end
    end
  end

endmodule
